// File: rtl/gate_bist.sv
// Exhaustive self-test sequencer for one combinational gate: sweeps every input
// vector and compares the DUT output against a reference delayed by LAT clocks.
module gate_bist #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned LAT   = 1,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic             dut_y,
  output logic [WIDTH-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_vec,
  output logic             fail_valid
);
  localparam int unsigned DRAIN_W = 3;
  localparam int unsigned ENTRY_W = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [2:0]           mode_q, mode_d;
  logic [WIDTH-1:0]     vec_q, vec_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [WIDTH-1:0]     fvec_q, fvec_d;
  logic                 fv_q, fv_d;

  logic                 exp_now;
  logic                 cmp_en;
  logic                 cmp_exp;
  logic [WIDTH-1:0]     cmp_vec;
  logic                 mismatch;

  function automatic logic gate_eval(input logic [2:0] m, input logic [WIDTH-1:0] v);
    case (m)
      3'd0:    return &v;
      3'd1:    return |v;
      3'd2:    return ^v;
      3'd3:    return ~&v;
      3'd4:    return ~|v;
      3'd5:    return ~^v;
      3'd6:    return v[0];
      default: return ~v[0];
    endcase
  endfunction

  assign exp_now = gate_eval(mode_q, vec_q);

  // Reference pipeline aligning {valid, expected, vector} with the DUT response.
  if (LAT > 0) begin : g_line
    logic [LAT-1:0][ENTRY_W-1:0] dl_q;
    logic [ENTRY_W-1:0]          dl_in;

    assign dl_in = {state_q == RUN, exp_now, vec_q};

    if (LAT == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dl_q <= '0;
        else        dl_q <= dl_in;
      end
    end else begin : g_many
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dl_q <= '0;
        else        dl_q <= {dl_q[LAT-2:0], dl_in};
      end
    end

    assign {cmp_en, cmp_exp, cmp_vec} = dl_q[LAT-1];
  end else begin : g_direct
    assign cmp_en  = (state_q == RUN);
    assign cmp_exp = exp_now;
    assign cmp_vec = vec_q;
  end

  assign mismatch = cmp_en && (dut_y != cmp_exp);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    vec_d   = vec_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fv_d    = fv_q;

    // Saturating error count; only the first failing vector is kept.
    if (mismatch) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (!fv_q) begin
        fv_d   = 1'b1;
        fvec_d = cmp_vec;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          vec_d   = '0;
          err_d   = '0;
          fvec_d  = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (vec_q == '1) begin
          if (LAT > 0) begin
            state_d = DRAIN;
            drain_d = DRAIN_W'(LAT - 1);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end else begin
          vec_d = vec_q + WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      vec_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      vec_q   <= vec_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fv_q    <= fv_d;
    end
  end

  assign vec_out    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fvec_q;
  assign fail_valid = fv_q;

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: three configurations share stimulus, each with
// its own behavioural gate model and a done-triggered checker.
module tb_gate_bist;
  typedef struct packed {
    int err;
    int fvec;
    int fv;
    int pass;
    int dcyc;
  } exp_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       start    = 1'b0;
  logic [2:0] mode     = 3'd0;
  int         fault    = 0;
  int         run_mode = 0;
  int         cyc      = 0;
  int         n_vec    = 0;
  int         n_err    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(input int err, input int fvec, input int dcyc);
    exp_t e;
    e.err  = err;
    e.fvec = fvec;
    e.fv   = (err != 0) ? 1 : 0;
    e.pass = (err == 0) ? 1 : 0;
    e.dcyc = dcyc;
    return e;
  endfunction

  // cfg0: WIDTH2/LAT1/ERR8, cfg1: WIDTH3/LAT0/ERR8, cfg2: WIDTH3/LAT2/ERR2
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W = (g == 0) ? 2 : 3;
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
    localparam int E = (g == 2) ? 2 : 8;

    logic [W-1:0] vec_out;
    logic [W-1:0] fail_vec;
    logic [E-1:0] err_count;
    logic         busy;
    logic         done;
    logic         pass;
    logic         fail_valid;
    logic         dut_y;
    logic [W-1:0] pipe [4];
    logic [W-1:0] dvec;
    logic [31:0]  all_out;
    exp_t         q[$];
    exp_t         e;

    // Gate under test: fault 0 correct, 1 OR gate, 2 stuck-at-0, 3 inverted.
    function automatic logic model(input int f, input int m, input logic [W-1:0] v);
      int   ones;
      logic r;
      ones = $countones(v);
      case (m)
        0:       r = (ones == W);
        1:       r = (ones != 0);
        2:       r = (ones % 2 == 1);
        3:       r = (ones != W);
        4:       r = (ones == 0);
        5:       r = (ones % 2 == 0);
        6:       r = v[0];
        default: r = !v[0];
      endcase
      case (f)
        0:       return r;
        1:       return (ones != 0);
        2:       return 1'b0;
        default: return !r;
      endcase
    endfunction

    always @(posedge clk) begin
      pipe[0] <= vec_out;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    assign dvec    = (L == 0) ? vec_out : pipe[(L == 0) ? 0 : L - 1];
    assign dut_y   = model(fault, run_mode, dvec);
    assign all_out = 32'({vec_out, busy, done, pass, err_count, fail_vec, fail_valid});

    gate_bist #(.WIDTH(W), .LAT(L), .ERR_W(E)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .dut_y     (dut_y),
      .vec_out   (vec_out),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_vec  (fail_vec),
      .fail_valid(fail_valid)
    );

    always @(negedge clk) begin
      if (rst_n && done) begin
        if (q.size() == 0) begin
          chk($sformatf("cfg%0d_spurious_done", g), 1, 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("cfg%0d_done_cycle", g), cyc, e.dcyc);
          chk($sformatf("cfg%0d_err_count", g), int'(err_count), e.err);
          chk($sformatf("cfg%0d_fail_vec", g), int'(fail_vec), e.fvec);
          chk($sformatf("cfg%0d_fail_valid", g), int'(fail_valid), e.fv);
          chk($sformatf("cfg%0d_pass", g), int'(pass), e.pass);
          chk($sformatf("cfg%0d_busy_in_done", g), int'(busy), 0);
        end
      end
    end
  end

  // Done lands in cycle 2^W+L+1 after acceptance, i.e. at cyc = accept + 2^W + L.
  task automatic run_case(input int m, input int f,
                          input int e0, input int v0, input int e1, input int v1,
                          input int e2, input int v2, input bit repulse, input bit sweep);
    int a;
    @(negedge clk);
    rst_n    = 1'b1;
    mode     = 3'(m);
    run_mode = m;
    fault    = f;
    start    = 1'b1;
    a        = cyc + 1;
    g_cfg[0].q.push_back(mk(e0, v0, a + 4 + 1));
    g_cfg[1].q.push_back(mk(e1, v1, a + 8 + 0));
    g_cfg[2].q.push_back(mk(e2, v2, a + 8 + 2));
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = repulse && (c == 2 || c == 6);
      if (repulse && c == 3) mode = 3'd0;
      if (sweep && c <= 6) begin
        chk($sformatf("cfg0_vec_out_c%0d", c), int'(g_cfg[0].vec_out), (c <= 4) ? c - 1 : 3);
        chk($sformatf("cfg0_busy_c%0d", c), int'(g_cfg[0].busy), (c <= 5) ? 1 : 0);
      end
    end
    chk("cfg0_hold_err", int'(g_cfg[0].err_count), e0);
    chk("cfg1_hold_err", int'(g_cfg[1].err_count), e1);
    chk("cfg2_hold_err", int'(g_cfg[2].err_count), e2);
  endtask

  task automatic abort_run();
    @(negedge clk);
    rst_n    = 1'b1;
    mode     = 3'd0;
    run_mode = 0;
    fault    = 3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("cfg1_abort_pre_err", int'(g_cfg[1].err_count), 2);
    rst_n = 1'b0;
    #1;
    chk("cfg0_abort_outs", int'(g_cfg[0].all_out), 0);
    chk("cfg1_abort_outs", int'(g_cfg[1].all_out), 0);
    chk("cfg2_abort_outs", int'(g_cfg[2].all_out), 0);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("cfg0_reset_outs", int'(g_cfg[0].all_out), 0);
    chk("cfg1_reset_outs", int'(g_cfg[1].all_out), 0);
    chk("cfg2_reset_outs", int'(g_cfg[2].all_out), 0);

    run_case(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    run_case(0, 1, 2, 1, 6, 1, 3, 1, 1'b0, 1'b0);
    run_case(5, 2, 2, 0, 4, 0, 3, 0, 1'b0, 1'b0);
    run_case(7, 3, 4, 0, 8, 0, 3, 0, 1'b0, 1'b0);
    run_case(2, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    run_case(6, 2, 2, 1, 4, 1, 3, 1, 1'b0, 1'b0);
    run_case(3, 1, 2, 0, 2, 0, 2, 0, 1'b0, 1'b0);
    abort_run();
    run_case(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    run_case(4, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    run_case(1, 2, 3, 1, 7, 1, 3, 1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("cfg0_pending", g_cfg[0].q.size(), 0);
    chk("cfg1_pending", g_cfg[1].q.size(), 0);
    chk("cfg2_pending", g_cfg[2].q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
